axi_lite_splitter_n: RTL

Parametrised AXI4-Lite 1-to-N splitter. It takes one AXI4-Lite slave port from the upstream interconnect and routes each transaction to one of NUM_MASTERS downstream AXI4-Lite master ports, selected by address slot. Transactions that decode to no port are answered locally with DECERR. It replaces the fixed three-port splitter in the peripheral subsystem; read and write paths are independent, with one outstanding transaction per direction.

---
 rtl/axi_lite_splitter_pkg.sv | 15 +
 rtl/axi_lite_splitter_decode.sv | 26 ++
 rtl/axi_lite_splitter_n.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_splitter_pkg.sv
// Shared types and constants for the AXI4-Lite 1-to-N splitter.
package axi_lite_splitter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} rd_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_splitter_decode.sv
// Address slot decoder: port index, hit flag and slot-relative address.
module axi_lite_splitter_decode
  import axi_lite_splitter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int SLOT_ADDR_BITS = 12,
  parameter int IDX_W          = idx_w(NUM_MASTERS)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [ADDR_WIDTH-1:0] rel_addr_o
);

  localparam int SLOT_W = ADDR_WIDTH - SLOT_ADDR_BITS;

  logic [SLOT_W-1:0] slot;

  assign slot       = addr_i[ADDR_WIDTH-1:SLOT_ADDR_BITS];
  // Compare at full slot width so high address bits can never alias onto a port.
  assign hit_o      = (64'(slot) < 64'(NUM_MASTERS));
  assign idx_o      = slot[IDX_W-1:0];
  assign rel_addr_o = {{SLOT_W{1'b0}}, addr_i[SLOT_ADDR_BITS-1:0]};

endmodule

// File: rtl/axi_lite_splitter_n.sv
// AXI4-Lite 1-to-N splitter: one outstanding transaction per direction, DECERR on unmapped slots.
module axi_lite_splitter_n
  import axi_lite_splitter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLOT_ADDR_BITS = 12
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [NUM_MASTERS*3-1:0]          M_AXI_AWPROT,
  output logic [NUM_MASTERS-1:0]            M_AXI_AWVALID,
  input  logic [NUM_MASTERS-1:0]            M_AXI_AWREADY,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [NUM_MASTERS*DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic [NUM_MASTERS-1:0]            M_AXI_WVALID,
  input  logic [NUM_MASTERS-1:0]            M_AXI_WREADY,
  input  logic [NUM_MASTERS*2-1:0]          M_AXI_BRESP,
  input  logic [NUM_MASTERS-1:0]            M_AXI_BVALID,
  output logic [NUM_MASTERS-1:0]            M_AXI_BREADY,
  output logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [NUM_MASTERS*3-1:0]          M_AXI_ARPROT,
  output logic [NUM_MASTERS-1:0]            M_AXI_ARVALID,
  input  logic [NUM_MASTERS-1:0]            M_AXI_ARREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [NUM_MASTERS*2-1:0]          M_AXI_RRESP,
  input  logic [NUM_MASTERS-1:0]            M_AXI_RVALID,
  output logic [NUM_MASTERS-1:0]            M_AXI_RREADY
);

  localparam int IDX_W  = idx_w(NUM_MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                   aw_hit, ar_hit;
  logic [IDX_W-1:0]       aw_idx, ar_idx;
  logic [ADDR_WIDTH-1:0]  aw_rel, ar_rel;
  logic [NUM_MASTERS-1:0] aw_sel, ar_sel;

  axi_lite_splitter_decode #(
    .NUM_MASTERS(NUM_MASTERS), .ADDR_WIDTH(ADDR_WIDTH), .SLOT_ADDR_BITS(SLOT_ADDR_BITS), .IDX_W(IDX_W)
  ) u_dec_aw (
    .addr_i(S_AXI_AWADDR), .hit_o(aw_hit), .idx_o(aw_idx), .rel_addr_o(aw_rel)
  );

  axi_lite_splitter_decode #(
    .NUM_MASTERS(NUM_MASTERS), .ADDR_WIDTH(ADDR_WIDTH), .SLOT_ADDR_BITS(SLOT_ADDR_BITS), .IDX_W(IDX_W)
  ) u_dec_ar (
    .addr_i(S_AXI_ARADDR), .hit_o(ar_hit), .idx_o(ar_idx), .rel_addr_o(ar_rel)
  );

  assign aw_sel = NUM_MASTERS'(1) << aw_idx;
  assign ar_sel = NUM_MASTERS'(1) << ar_idx;

  wr_state_t              wr_state_q;
  logic                   awready_q, wready_q, bvalid_q;
  logic [1:0]             bresp_q;
  logic [ADDR_WIDTH-1:0]  m_awaddr_q;
  logic [2:0]             m_awprot_q;
  logic [DATA_WIDTH-1:0]  m_wdata_q;
  logic [STRB_W-1:0]      m_wstrb_q;
  logic [NUM_MASTERS-1:0] m_awvalid_q, m_wvalid_q, m_bready_q, wr_sel_q;

  rd_state_t              rd_state_q;
  logic                   arready_q, rvalid_q;
  logic [1:0]             rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [ADDR_WIDTH-1:0]  m_araddr_q;
  logic [2:0]             m_arprot_q;
  logic [NUM_MASTERS-1:0] m_arvalid_q, m_rready_q, rd_sel_q;

  logic [1:0]             m_bresp_sel, m_rresp_sel;
  logic [DATA_WIDTH-1:0]  m_rdata_sel;
  logic                   aw_hs, ar_hs;
  logic [NUM_MASTERS-1:0] aw_pend, w_pend;

  always_comb begin
    m_bresp_sel = '0;
    m_rresp_sel = '0;
    m_rdata_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (wr_sel_q[k]) m_bresp_sel = M_AXI_BRESP[k*2 +: 2];
      if (rd_sel_q[k]) begin
        m_rresp_sel = M_AXI_RRESP[k*2 +: 2];
        m_rdata_sel = M_AXI_RDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // AW and W are only ever accepted together, so the two readies move as a pair.
  assign aw_hs   = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign ar_hs   = arready_q && S_AXI_ARVALID;
  assign aw_pend = m_awvalid_q & ~M_AXI_AWREADY;
  assign w_pend  = m_wvalid_q & ~M_AXI_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q  <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      m_awaddr_q  <= '0;
      m_awprot_q  <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
      wr_sel_q    <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            m_awaddr_q <= aw_rel;
            m_awprot_q <= S_AXI_AWPROT;
            m_wdata_q  <= S_AXI_WDATA;
            m_wstrb_q  <= S_AXI_WSTRB;
            if (aw_hit) begin
              wr_sel_q    <= aw_sel;
              m_awvalid_q <= aw_sel;
              m_wvalid_q  <= aw_sel;
              wr_state_q  <= W_FWD;
            end else begin
              wr_sel_q   <= '0;
              bresp_q    <= RESP_DECERR;
              bvalid_q   <= 1'b1;
              wr_state_q <= W_RESP;
            end
          end else begin
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID;
            wready_q  <= S_AXI_AWVALID && S_AXI_WVALID;
          end
        end
        W_FWD: begin
          m_awvalid_q <= aw_pend;
          m_wvalid_q  <= w_pend;
          if (aw_pend == '0 && w_pend == '0) begin
            m_bready_q <= wr_sel_q;
            wr_state_q <= W_WAITB;
          end
        end
        W_WAITB: begin
          if (|(m_bready_q & M_AXI_BVALID)) begin
            m_bready_q <= '0;
            bresp_q    <= m_bresp_sel;
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          // Arm the readies on exit so a waiting request lands in the first IDLE cycle.
          if (S_AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            awready_q  <= S_AXI_AWVALID && S_AXI_WVALID;
            wready_q   <= S_AXI_AWVALID && S_AXI_WVALID;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q  <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      m_araddr_q  <= '0;
      m_arprot_q  <= '0;
      m_arvalid_q <= '0;
      m_rready_q  <= '0;
      rd_sel_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q  <= 1'b0;
            m_araddr_q <= ar_rel;
            m_arprot_q <= S_AXI_ARPROT;
            if (ar_hit) begin
              rd_sel_q    <= ar_sel;
              m_arvalid_q <= ar_sel;
              rd_state_q  <= R_FWD;
            end else begin
              rd_sel_q   <= '0;
              rresp_q    <= RESP_DECERR;
              rdata_q    <= '0;
              rvalid_q   <= 1'b1;
              rd_state_q <= R_RESP;
            end
          end else begin
            arready_q <= S_AXI_ARVALID;
          end
        end
        R_FWD: begin
          if (|(m_arvalid_q & M_AXI_ARREADY)) begin
            m_arvalid_q <= '0;
            m_rready_q  <= rd_sel_q;
            rd_state_q  <= R_WAITR;
          end
        end
        R_WAITR: begin
          if (|(m_rready_q & M_AXI_RVALID)) begin
            m_rready_q <= '0;
            rdata_q    <= m_rdata_sel;
            rresp_q    <= m_rresp_sel;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= S_AXI_ARVALID;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign M_AXI_AWADDR  = {NUM_MASTERS{m_awaddr_q}};
  assign M_AXI_AWPROT  = {NUM_MASTERS{m_awprot_q}};
  assign M_AXI_AWVALID = m_awvalid_q;
  assign M_AXI_WDATA   = {NUM_MASTERS{m_wdata_q}};
  assign M_AXI_WSTRB   = {NUM_MASTERS{m_wstrb_q}};
  assign M_AXI_WVALID  = m_wvalid_q;
  assign M_AXI_BREADY  = m_bready_q;
  assign M_AXI_ARADDR  = {NUM_MASTERS{m_araddr_q}};
  assign M_AXI_ARPROT  = {NUM_MASTERS{m_arprot_q}};
  assign M_AXI_ARVALID = m_arvalid_q;
  assign M_AXI_RREADY  = m_rready_q;

endmodule
